// File: rtl/framer.sv
// +----------------------------------------------------------------------------+
// | Module      : framer                                                       |
// | Description : Builds an 11-bit async serial frame image (start, data,      |
// |               optional parity, stop bits, idle fill) and registers it.     |
// |               Optional external parity enabled by FRAMER_EXT_PARITY_EN.    |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
`default_nettype none

module framer (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  Din,
  input  logic        p_o,
  input  logic        dL,
  input  logic [1:0]  p,
  input  logic        s,
  output logic [10:0] frame
);

  localparam logic [10:0] c_IDLE = 11'h7FF;

  logic [7:0]  w_data_mask;
  logic        w_data_xor;
  logic        w_par_en;
  logic        w_par_bit;
  logic [3:0]  w_par_pos;
  logic [3:0]  w_stop_pos;
  logic [10:0] w_frame;
  logic [10:0] r_frame;

`ifndef FRAMER_EXT_PARITY_EN
  logic w_unused_p_o;
  assign w_unused_p_o = p_o;
`endif

  assign w_data_mask = dL ? 8'hFF : 8'h7F;
  assign w_data_xor  = ^(Din & w_data_mask);
  assign w_par_pos   = dL ? 4'd9 : 4'd8;
  assign w_stop_pos  = w_par_en ? (w_par_pos + 4'd1) : w_par_pos;

  always_comb begin
    w_par_en  = 1'b0;
    w_par_bit = 1'b1;
    case (p)
      2'b01: begin
        w_par_en  = 1'b1;
        w_par_bit = ~w_data_xor;
      end
      2'b10: begin
        w_par_en  = 1'b1;
        w_par_bit = w_data_xor;
      end
`ifdef FRAMER_EXT_PARITY_EN
      2'b11: begin
        w_par_en  = 1'b1;
        w_par_bit = p_o;
      end
`endif
      default: begin
        w_par_en  = 1'b0;
        w_par_bit = 1'b1;
      end
    endcase
  end

  // Start from all-ones so idle fill and stop bits need no separate clearing.
  always_comb begin
    w_frame    = c_IDLE;
    w_frame[0] = 1'b0;
    w_frame[7:1] = Din[6:0];
    if (dL) begin
      w_frame[8] = Din[7];
    end
    if (w_par_en) begin
      w_frame[w_par_pos] = w_par_bit;
    end
    if (w_stop_pos <= 4'd10) begin
      w_frame[w_stop_pos] = 1'b1;
    end
    // Second stop bit only fits when it stays within the 11-bit image.
    if (s && (w_stop_pos < 4'd10)) begin
      w_frame[w_stop_pos + 4'd1] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_frame <= c_IDLE;
    end else begin
      r_frame <= w_frame;
    end
  end

  assign frame = r_frame;

endmodule

`default_nettype wire

// File: tb/tb_framer.sv
// Directed self-checking bench for framer; expected frames are hand-computed.
`default_nettype none

module tb_framer;

  logic        clk;
  logic        rst;
  logic [7:0]  Din;
  logic        p_o;
  logic        dL;
  logic [1:0]  p;
  logic        s;
  logic [10:0] frame;

  int checks;
  int errors;

  framer dut (
    .clk   (clk),
    .rst   (rst),
    .Din   (Din),
    .p_o   (p_o),
    .dL    (dL),
    .p     (p),
    .s     (s),
    .frame (frame)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [10:0] exp);
    checks++;
    assert (frame === exp) else begin
      errors++;
      $error("FAIL %s: frame=%h expected=%h", tag, frame, exp);
    end
  endtask

  task automatic apply(input logic [7:0] d, input logic l, input logic [1:0] pm,
                       input logic st, input logic po);
    Din = d; dL = l; p = pm; s = st; p_o = po;
  endtask

  task automatic step(input string tag, input logic [7:0] d, input logic l,
                      input logic [1:0] pm, input logic st, input logic po,
                      input logic [10:0] exp);
    apply(d, l, pm, st, po);
    @(posedge clk);
    #1;
    check(tag, exp);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b0;
    apply(8'h00, 1'b0, 2'b00, 1'b0, 1'b0);

    @(posedge clk); #1;
    check("reset_state", 11'h7FF);

    rst = 1'b1;
    step("hAB_7b_odd_2stop",   8'hAB, 1'b0, 2'b01, 1'b1, 1'b0, 11'h756);
    step("hAB_7b_even_2stop",  8'hAB, 1'b0, 2'b10, 1'b1, 1'b0, 11'h656);
    step("hAB_8b_odd_1stop",   8'hAB, 1'b1, 2'b01, 1'b0, 1'b0, 11'h556);
    step("hAB_8b_even_1stop",  8'hAB, 1'b1, 2'b10, 1'b0, 1'b0, 11'h756);
    step("h6D_8b_nopar",       8'h6D, 1'b1, 2'b00, 1'b0, 1'b0, 11'h6DA);
    step("h00_8b_even_drop",   8'h00, 1'b1, 2'b10, 1'b1, 1'b0, 11'h400);
    step("h80_7b_odd_ignd7",   8'h80, 1'b0, 2'b01, 1'b0, 1'b0, 11'h700);
    step("h80_7b_even_ignd7",  8'h80, 1'b0, 2'b10, 1'b0, 1'b0, 11'h600);
    step("h80_8b_odd_2stop",   8'h80, 1'b1, 2'b01, 1'b1, 1'b0, 11'h500);
`ifdef FRAMER_EXT_PARITY_EN
    step("hFF_8b_ext_po0",     8'hFF, 1'b1, 2'b11, 1'b0, 1'b0, 11'h5FE);
    step("h00_7b_ext_po0",     8'h00, 1'b0, 2'b11, 1'b0, 1'b0, 11'h600);
    step("h00_7b_ext_po1",     8'h00, 1'b0, 2'b11, 1'b0, 1'b1, 11'h700);
`else
    step("hFF_8b_ext_off",     8'hFF, 1'b1, 2'b11, 1'b0, 1'b0, 11'h7FE);
    step("h00_7b_ext_off_po0", 8'h00, 1'b0, 2'b11, 1'b0, 1'b0, 11'h700);
    step("h55_8b_ext_off_po1", 8'h55, 1'b1, 2'b11, 1'b0, 1'b1, 11'h6AA);
`endif

    // Reset overrides live inputs and holds idle across edges.
    step("pre_reset_load",     8'h00, 1'b1, 2'b10, 1'b1, 1'b0, 11'h400);
    rst = 1'b0;
    step("reset_override",     8'h00, 1'b1, 2'b10, 1'b1, 1'b0, 11'h7FF);
    step("reset_hold",         8'h6D, 1'b1, 2'b00, 1'b0, 1'b0, 11'h7FF);
    rst = 1'b1;
    step("first_after_reset",  8'h00, 1'b0, 2'b01, 1'b1, 1'b0, 11'h700);

    // Mid-cycle input change must not show until the next edge.
    #2;
    apply(8'h6D, 1'b1, 2'b00, 1'b0, 1'b0);
    #2;
    check("midcycle_hold", 11'h700);
    @(posedge clk); #1;
    check("midcycle_update", 11'h6DA);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/framer.md
FRAMER -- requirements
Module: framer

Interface
REQ-001 clk  input  1  sole clock; all state updates on rising edge.
REQ-002 rst  input  1  reset, synchronous to clk, active-low.
REQ-003 Din  input  8  parallel data byte; Din[0] transmitted first.
REQ-004 p_o  input  1  externally supplied parity bit, used only in parity mode 2'b11.
REQ-005 frame  output  11  registered serial frame image; frame[0] transmitted first.
REQ-006 dL  input  1  data length: 0 = 7 bits (Din[6:0]), 1 = 8 bits (Din[7:0]).
REQ-007 p  input  2  parity mode: 00 none, 01 odd, 10 even, 11 external (p_o).
REQ-008 s  input  1  stop bits: 0 = one, 1 = two.

Function
REQ-009 Inputs SHALL be sampled every rising clk edge with rst=1; frame SHALL reflect them one cycle later (latency 1, no handshake, no enable).
REQ-010 Frame layout, LSB first: start bit 0 at frame[0], then data bits, then the parity bit (if enabled), then the stop bits (1), then idle fill 1 to frame[10].
REQ-011 Data bit i of the frame SHALL be Din[i], occupying frame[1+i] for i < data length.
REQ-012 Odd mode: parity bit SHALL make the total count of 1s over the data bits plus parity odd; even mode: even.
REQ-013 Parity SHALL be computed only over the selected data bits; Din[7] SHALL be ignored when dL=0.
REQ-014 Mode 00: no parity slot; stop bits SHALL follow the last data bit directly.
REQ-015 8 data bits + parity + 2 stop bits (12 bits) exceeds 11 bits: the second stop bit SHALL be dropped; frame[10] = first stop bit.
REQ-016 All unused positions above the last stop bit SHALL be 1.
REQ-017 The frame SHALL be built combinationally from the current inputs and registered; the previous frame SHALL NOT influence the next.
REQ-018 Input changes between edges SHALL have no effect on frame until the next edge.

Reset
REQ-019 rst=0 at a rising edge SHALL load frame = 11'h7FF (line idle), overriding all inputs.
REQ-020 While rst=0 frame SHALL hold 11'h7FF; the pre-reset frame SHALL NOT reappear.
REQ-021 The first rising edge with rst=1 SHALL load the frame from the current inputs.

Configuration
REQ-022 Macro FRAMER_EXT_PARITY_EN defined: mode 11 SHALL insert p_o as the parity bit in the parity slot.
REQ-023 Macro FRAMER_EXT_PARITY_EN undefined: mode 11 SHALL behave exactly as mode 00, and p_o SHALL be ignored.

Verification
REQ-024 Din=8'hAB, dL=0, s=1: p=01 -> frame=11'h756; p=10 -> frame=11'h656.
REQ-025 Din=8'hAB, dL=1, s=0, p=01 -> frame=11'h556; p=10 -> frame=11'h756.
REQ-026 Din=8'h6D, dL=1, s=0, p=00 -> frame=11'h6DA; Din=8'h00, dL=1, s=1, p=10 -> frame=11'h400 (second stop dropped).
REQ-027 Din=8'hFF, dL=1, s=0, p=11, p_o=0 -> frame=11'h5FE with FRAMER_EXT_PARITY_EN, 11'h7FE without.
REQ-028 Any frame loaded, then rst=0 for one edge -> frame=11'h7FF; rst=1, Din=8'h00, dL=0, s=1, p=01 -> next edge frame=11'h700.
REQ-029 Change inputs mid-cycle -> frame unchanged until the next rising edge, then matches the new inputs.
